matrix_store_ctrl: RTL and testbench

Second-generation matrix store for the matrix calculator datapath. It holds up to SLOTS matrices of any size from 1x1 to MAX_DIM x MAX_DIM, each indexed by its dimensions plus an age index. It takes element streams through a valid/ready write port and replays a selected matrix through a valid/ready burst port with a last flag. When a size class is full, the oldest matrix of that size is replaced automatically. It sits between the input parser/ALU result path and the display/operand fetch logic.

---
 rtl/matrix_store_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_matrix_store_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store_ctrl.sv
// Slot-based matrix store: streams matrices in through a valid/ready write port,
// indexes them by (rows, cols, age) and replays a selected one as a burst.
module matrix_store_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 5,
    parameter int SLOTS      = 8,
    parameter int PER_SIZE   = 2,
    localparam int IDX_W     = (PER_SIZE > 1) ? $clog2(PER_SIZE) : 1,
    localparam int QCNT_W    = $clog2(PER_SIZE + 1),
    localparam int FREE_W    = $clog2(SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_start,
    input  logic [2:0]            i_wr_rows,
    input  logic [2:0]            i_wr_cols,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_wr_done,
    output logic                  o_wr_err,
    input  logic                  i_rd_start,
    input  logic [2:0]            i_rd_rows,
    input  logic [2:0]            i_rd_cols,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_last,
    input  logic                  i_out_ready,
    output logic                  o_rd_err,
    input  logic [2:0]            i_q_rows,
    input  logic [2:0]            i_q_cols,
    output logic [QCNT_W-1:0]     o_q_count,
    output logic [FREE_W-1:0]     o_free_count,
    input  logic                  i_clr,
    output logic                  o_busy
);
    localparam int DIM_W  = 3;
    localparam int PROD_W = 2 * DIM_W;
    localparam int MAT_SZ = MAX_DIM * MAX_DIM;
    localparam int ELEM_W = (MAT_SZ > 1) ? $clog2(MAT_SZ) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int ADDR_W = $clog2(SLOTS * MAT_SZ);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_READ = 2'd2} state_t;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != {DIM_W{1'b0}}) && (int'(d) <= MAX_DIM);
    endfunction

    function automatic logic [PROD_W-1:0] prod(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return PROD_W'(r) * PROD_W'(c);
    endfunction

    state_t                r_state, w_next;
    logic [SLOTS-1:0]      r_used, r_vld;
    logic [DIM_W-1:0]      r_slot_rows [SLOTS];
    logic [DIM_W-1:0]      r_slot_cols [SLOTS];
    logic [IDX_W-1:0]      r_slot_age  [SLOTS];
    logic [DATA_WIDTH-1:0] r_mem [SLOTS*MAT_SZ];
    logic [SLOT_W-1:0]     r_tgt_slot;
    logic [DIM_W-1:0]      r_wr_rows, r_wr_cols;
    logic [PROD_W-1:0]     r_wr_last, r_rd_last;
    logic [ELEM_W-1:0]     r_wr_cnt, r_rd_cnt;
    logic [ADDR_W-1:0]     r_rd_base;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last, r_wr_done, r_wr_err, r_rd_err;
    logic [FREE_W-1:0]     r_free_count;

    logic [DIM_W-1:0]  w_lk_rows, w_lk_cols;
    logic [QCNT_W-1:0] w_wr_cls_cnt, w_q_cnt;
    logic [SLOT_W-1:0] w_evict_slot, w_free_slot, w_rd_slot;
    logic              w_free_found, w_rd_hit;
    logic              w_idle, w_clr_go, w_wr_req, w_wr_full_cls, w_wr_go, w_wr_bad;
    logic              w_rd_req, w_rd_go, w_rd_bad, w_wr_beat, w_wr_fin, w_rd_acc, w_rd_fin;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_base_new, w_rd_next_addr;

    // During WRITE the class lookup follows the latched dims so the commit age is stable.
    assign w_lk_rows = (r_state == S_IDLE) ? i_wr_rows : r_wr_rows;
    assign w_lk_cols = (r_state == S_IDLE) ? i_wr_cols : r_wr_cols;

    // Slot table search: class counts, eviction victim, free slot, read hit.
    always_comb begin
        w_wr_cls_cnt = {QCNT_W{1'b0}};
        w_q_cnt      = {QCNT_W{1'b0}};
        w_evict_slot = {SLOT_W{1'b0}};
        w_free_slot  = {SLOT_W{1'b0}};
        w_rd_slot    = {SLOT_W{1'b0}};
        w_free_found = 1'b0;
        w_rd_hit     = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (r_vld[i] && r_slot_rows[i] == w_lk_rows && r_slot_cols[i] == w_lk_cols) begin
                w_wr_cls_cnt = w_wr_cls_cnt + QCNT_W'(1'b1);
                if (r_slot_age[i] == {IDX_W{1'b0}}) w_evict_slot = SLOT_W'(i);
            end
            if (r_vld[i] && r_slot_rows[i] == i_q_rows && r_slot_cols[i] == i_q_cols)
                w_q_cnt = w_q_cnt + QCNT_W'(1'b1);
            if (r_vld[i] && r_slot_rows[i] == i_rd_rows && r_slot_cols[i] == i_rd_cols
                && r_slot_age[i] == i_rd_idx) begin
                w_rd_hit  = 1'b1;
                w_rd_slot = SLOT_W'(i);
            end
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!r_used[i]) begin
                w_free_found = 1'b1;
                w_free_slot  = SLOT_W'(i);
            end
        end
    end

    assign w_idle         = (r_state == S_IDLE);
    assign w_clr_go       = w_idle && i_clr;
    assign w_wr_req       = w_idle && !i_clr && i_wr_start;
    assign w_wr_full_cls  = (w_wr_cls_cnt == QCNT_W'(PER_SIZE));
    assign w_wr_go        = w_wr_req && dim_ok(i_wr_rows) && dim_ok(i_wr_cols) && (w_wr_full_cls || w_free_found);
    assign w_wr_bad       = w_wr_req && !w_wr_go;
    assign w_rd_req       = w_idle && !i_clr && !i_wr_start && i_rd_start;
    assign w_rd_go        = w_rd_req && dim_ok(i_rd_rows) && dim_ok(i_rd_cols) && w_rd_hit;
    assign w_rd_bad       = w_rd_req && !w_rd_go;
    assign w_wr_beat      = (r_state == S_WRITE) && i_wr_valid;
    assign w_wr_fin       = w_wr_beat && (PROD_W'(r_wr_cnt) == r_wr_last);
    assign w_rd_acc       = (r_state == S_READ) && i_out_ready;
    assign w_rd_fin       = w_rd_acc && r_out_last;
    assign w_wr_addr      = ADDR_W'(r_tgt_slot) * ADDR_W'(MAT_SZ) + ADDR_W'(r_wr_cnt);
    assign w_rd_base_new  = ADDR_W'(w_rd_slot) * ADDR_W'(MAT_SZ);
    assign w_rd_next_addr = r_rd_base + ADDR_W'(r_rd_cnt) + ADDR_W'(1'b1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_wr_go)      w_next = S_WRITE;
                else if (w_rd_go) w_next = S_READ;
                else              w_next = S_IDLE;
            end
            S_WRITE: begin
                if (w_wr_fin) w_next = S_IDLE;
                else          w_next = S_WRITE;
            end
            S_READ: begin
                if (w_rd_fin) w_next = S_IDLE;
                else          w_next = S_READ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state-decoded outputs.
    always_comb begin
        o_wr_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE:  o_busy      = 1'b0;
            S_WRITE: o_wr_ready  = 1'b1;
            S_READ:  o_out_valid = 1'b1;
            default: o_busy      = 1'b0;
        endcase
    end

    // Element storage; contents carry no reset since slot validity gates every use.
    always_ff @(posedge clk) begin
        if (w_wr_beat) r_mem[w_wr_addr] <= i_wr_data;
    end

    // Slot table, write/read sequencing and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_used       <= {SLOTS{1'b0}};
            r_vld        <= {SLOTS{1'b0}};
            for (int i = 0; i < SLOTS; i++) begin
                r_slot_rows[i] <= {DIM_W{1'b0}};
                r_slot_cols[i] <= {DIM_W{1'b0}};
                r_slot_age[i]  <= {IDX_W{1'b0}};
            end
            r_tgt_slot   <= {SLOT_W{1'b0}};
            r_wr_rows    <= {DIM_W{1'b0}};
            r_wr_cols    <= {DIM_W{1'b0}};
            r_wr_last    <= {PROD_W{1'b0}};
            r_wr_cnt     <= {ELEM_W{1'b0}};
            r_rd_last    <= {PROD_W{1'b0}};
            r_rd_cnt     <= {ELEM_W{1'b0}};
            r_rd_base    <= {ADDR_W{1'b0}};
            r_out_data   <= {DATA_WIDTH{1'b0}};
            r_out_last   <= 1'b0;
            r_wr_done    <= 1'b0;
            r_wr_err     <= 1'b0;
            r_rd_err     <= 1'b0;
            r_free_count <= FREE_W'(SLOTS);
        end else begin
            r_wr_done <= w_wr_fin;
            r_wr_err  <= w_wr_bad;
            r_rd_err  <= w_rd_bad;
            if (w_clr_go) begin
                r_used       <= {SLOTS{1'b0}};
                r_vld        <= {SLOTS{1'b0}};
                r_free_count <= FREE_W'(SLOTS);
            end else if (w_wr_go) begin
                r_wr_rows <= i_wr_rows;
                r_wr_cols <= i_wr_cols;
                r_wr_last <= prod(i_wr_rows, i_wr_cols) - PROD_W'(1'b1);
                r_wr_cnt  <= {ELEM_W{1'b0}};
                if (w_wr_full_cls) begin
                    // Recycle the oldest slot of the class; survivors move one age down.
                    r_tgt_slot          <= w_evict_slot;
                    r_vld[w_evict_slot] <= 1'b0;
                    for (int i = 0; i < SLOTS; i++) begin
                        if (r_vld[i] && r_slot_rows[i] == i_wr_rows && r_slot_cols[i] == i_wr_cols
                            && SLOT_W'(i) != w_evict_slot)
                            r_slot_age[i] <= r_slot_age[i] - IDX_W'(1'b1);
                    end
                end else begin
                    r_tgt_slot          <= w_free_slot;
                    r_used[w_free_slot] <= 1'b1;
                    r_free_count        <= r_free_count - FREE_W'(1'b1);
                end
            end else if (w_wr_fin) begin
                r_vld[r_tgt_slot]       <= 1'b1;
                r_slot_rows[r_tgt_slot] <= r_wr_rows;
                r_slot_cols[r_tgt_slot] <= r_wr_cols;
                r_slot_age[r_tgt_slot]  <= IDX_W'(w_wr_cls_cnt);
            end else if (w_wr_beat) begin
                r_wr_cnt <= r_wr_cnt + ELEM_W'(1'b1);
            end
            if (w_rd_go) begin
                r_rd_base  <= w_rd_base_new;
                r_rd_cnt   <= {ELEM_W{1'b0}};
                r_rd_last  <= prod(i_rd_rows, i_rd_cols) - PROD_W'(1'b1);
                r_out_data <= r_mem[w_rd_base_new];
                r_out_last <= (prod(i_rd_rows, i_rd_cols) == PROD_W'(1'b1));
            end else if (w_rd_fin) begin
                r_out_last <= 1'b0;
            end else if (w_rd_acc) begin
                r_rd_cnt   <= r_rd_cnt + ELEM_W'(1'b1);
                r_out_data <= r_mem[w_rd_next_addr];
                r_out_last <= (PROD_W'(r_rd_cnt) + PROD_W'(1'b1) == r_rd_last);
            end
        end
    end

    assign o_wr_done    = r_wr_done;
    assign o_wr_err     = r_wr_err;
    assign o_rd_err     = r_rd_err;
    assign o_out_data   = r_out_data;
    assign o_out_last   = r_out_last;
    assign o_q_count    = w_q_cnt;
    assign o_free_count = r_free_count;

endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Scoreboard bench for matrix_store_ctrl: a list-of-matrices reference model
// predicts store/read outcomes; a monitor checks every accepted read beat.
module tb_matrix_store_ctrl;
    localparam int DW = 8, MD = 5, SL = 8, PS = 2;
    localparam int MW = MD * MD * DW;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          i_wr_start = 1'b0, i_wr_valid = 1'b0, i_rd_start = 1'b0, i_out_ready = 1'b0, i_clr = 1'b0;
    logic [2:0]    i_wr_rows = 3'd0, i_wr_cols = 3'd0, i_rd_rows = 3'd0, i_rd_cols = 3'd0, i_q_rows = 3'd0, i_q_cols = 3'd0;
    logic [DW-1:0] i_wr_data = 8'd0;
    logic [0:0]    i_rd_idx = 1'b0;
    logic          o_wr_ready, o_wr_done, o_wr_err, o_out_valid, o_out_last, o_rd_err, o_busy;
    logic [DW-1:0] o_out_data;
    logic [1:0]    o_q_count;
    logic [3:0]    o_free_count;

    matrix_store_ctrl #(.DATA_WIDTH(DW), .MAX_DIM(MD), .SLOTS(SL), .PER_SIZE(PS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wr_start(i_wr_start), .i_wr_rows(i_wr_rows), .i_wr_cols(i_wr_cols),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
        .i_rd_start(i_rd_start), .i_rd_rows(i_rd_rows), .i_rd_cols(i_rd_cols), .i_rd_idx(i_rd_idx),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .i_out_ready(i_out_ready), .o_rd_err(o_rd_err),
        .i_q_rows(i_q_rows), .i_q_cols(i_q_cols), .o_q_count(o_q_count),
        .o_free_count(o_free_count), .i_clr(i_clr), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] r; logic [2:0] c; logic [MW-1:0] d; } mat_t;
    typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
    mat_t  model[$];   // committed matrices, oldest first
    beat_t sb[$];      // expected read beats
    int    n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] d);
        return (d >= 3'd1) && (int'(d) <= MD);
    endfunction

    function automatic int cls_cnt(input logic [2:0] r, input logic [2:0] c);
        int n = 0;
        foreach (model[i]) if (model[i].r == r && model[i].c == c) n++;
        return n;
    endfunction

    function automatic logic [MW-1:0] seqd(input int base);
        logic [MW-1:0] v = '0;
        for (int k = 0; k < MD * MD; k++) v[k*DW +: DW] = 8'(base + k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [2:0] r, input logic [2:0] c, input logic [MW-1:0] d, input int gap_max);
        bit ok;
        int n;
        ok = legal(r) && legal(c) && (cls_cnt(r, c) == PS || model.size() < SL);
        if (ok && cls_cnt(r, c) == PS) begin
            for (int i = 0; i < model.size(); i++)
                if (model[i].r == r && model[i].c == c) begin model.delete(i); break; end
        end
        i_wr_rows = r; i_wr_cols = c; i_wr_start = 1'b1;
        tick();
        i_wr_start = 1'b0;
        @(negedge clk);
        i_q_rows = r; i_q_cols = c;
        #1;
        chk("wr_err", o_wr_err, !ok);
        chk("wr_ready", o_wr_ready, ok);
        chk("busy_wr", o_busy, ok);
        chk("q_count_start", o_q_count, legal(r) && legal(c) ? cls_cnt(r, c) : int'(o_q_count));
        chk("free_start", o_free_count, SL - model.size() - (ok ? 1 : 0));
        if (!ok) return;
        n = int'(r) * int'(c);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap_max)) begin i_wr_valid = 1'b0; tick(); end
            i_wr_valid = 1'b1; i_wr_data = d[k*DW +: DW];
            tick();
        end
        i_wr_valid = 1'b0;
        @(negedge clk);
        model.push_back('{r: r, c: c, d: d});
        chk("wr_done", o_wr_done, 1);
        chk("wr_ready_end", o_wr_ready, 0);
        chk("q_count_commit", o_q_count, cls_cnt(r, c));
        chk("free_commit", o_free_count, SL - model.size());
    endtask

    function automatic bit pat(input int mode, input int ph);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (ph % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_read(input logic [2:0] r, input logic [2:0] c, input int idx, input int mode);
        bit ok, tmo;
        int n, seen, ph;
        ok = legal(r) && legal(c) && idx < cls_cnt(r, c);
        if (ok) begin
            seen = 0;
            n = int'(r) * int'(c);
            foreach (model[i]) if (model[i].r == r && model[i].c == c) begin
                if (seen == idx)
                    for (int k = 0; k < n; k++) sb.push_back('{d: model[i].d[k*DW +: DW], l: (k == n - 1)});
                seen++;
            end
        end
        i_rd_rows = r; i_rd_cols = c; i_rd_idx = 1'(idx); i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        ph = 0;
        i_out_ready = pat(mode, ph);
        @(negedge clk);
        chk("rd_err", o_rd_err, !ok);
        chk("rd_valid_start", o_out_valid, ok);
        if (!ok) begin i_out_ready = 1'b0; return; end
        tmo = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin tmo = 1'b0; break; end
            ph++;
            i_out_ready = pat(mode, ph);
        end
        i_out_ready = 1'b0;
        if (tmo) begin
            chk("rd_timeout_pending", sb.size(), 0);
            sb.delete();
        end else begin
            @(negedge clk);
            chk("busy_after_read", o_busy, 0);
            chk("valid_after_read", o_out_valid, 0);
        end
    endtask

    // Monitor: pops expected beats on every handshake and checks hold during stalls.
    bit            stall_prev = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    beat_t         eb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && o_out_valid) begin
                chk("stall_data", o_out_data, hold_d);
                chk("stall_last", o_out_last, hold_l);
            end
            stall_prev = o_out_valid && !i_out_ready;
            hold_d = o_out_data;
            hold_l = o_out_last;
            if (o_out_valid && i_out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", o_out_data);
                end else begin
                    eb = sb.pop_front();
                    chk("out_data", o_out_data, eb.d);
                    chk("out_last", o_out_last, eb.l);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        logic [MW-1:0] rd;
        int op, ri, rr, cc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_free", o_free_count, SL);
        chk("rst_busy", o_busy, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        chk("rst_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);

        do_store(3'd2, 3'd3, seqd(8'h01), 0);
        do_store(3'd2, 3'd3, seqd(8'h11), 0);
        do_store(3'd2, 3'd3, seqd(8'h21), 0);
        do_read(3'd2, 3'd3, 0, 0);
        do_read(3'd2, 3'd3, 1, 0);
        do_store(3'd3, 3'd4, seqd(8'h31), 0);
        do_read(3'd3, 3'd4, 0, 1);

        do_store(3'd1, 3'd1, seqd(8'h41), 1);
        do_store(3'd5, 3'd5, seqd(8'h50), 1);
        do_store(3'd1, 3'd5, seqd(8'h70), 0);
        do_store(3'd4, 3'd1, seqd(8'h80), 0);
        do_store(3'd2, 3'd2, seqd(8'h90), 0);
        do_store(3'd3, 3'd3, seqd(8'hA0), 0);   // store is full -> rejected
        do_read(3'd1, 3'd1, 1, 0);              // idx beyond class count
        do_read(3'd4, 3'd4, 0, 0);              // empty class
        do_store(3'd0, 3'd2, seqd(8'hB0), 0);   // illegal rows
        do_read(3'd6, 3'd1, 0, 0);              // illegal rows
        do_read(3'd1, 3'd1, 0, 0);              // single-beat burst
        do_read(3'd5, 3'd5, 0, 2);
        do_store(3'd2, 3'd3, seqd(8'hC0), 0);   // eviction with no free slot
        do_read(3'd2, 3'd3, 0, 0);
        do_read(3'd2, 3'd3, 1, 2);

        // Reset in the middle of a 5x5 store.
        i_wr_rows = 3'd5; i_wr_cols = 3'd5; i_wr_start = 1'b1;
        tick();
        i_wr_start = 1'b0;
        for (int k = 0; k < 3; k++) begin i_wr_valid = 1'b1; i_wr_data = 8'(k + 1); tick(); end
        i_wr_valid = 1'b0;
        rst_n = 1'b0;
        model.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_q_rows = 3'd5; i_q_cols = 3'd5;
        @(negedge clk);
        chk("rst_mid_free", o_free_count, SL);
        chk("rst_mid_q55", o_q_count, 0);
        chk("rst_mid_wr_ready", o_wr_ready, 0);

        // Randomised mix of stores, reads and clears.
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 19);
            if (op < 9) begin
                rr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 3);
                cc = $urandom_range(1, 3);
                for (int k = 0; k < MD * MD; k++) rd[k*DW +: DW] = 8'($urandom);
                do_store(3'(rr), 3'(cc), rd, $urandom_range(0, 2));
            end else if (op < 18) begin
                if (model.size() > 0 && $urandom_range(0, 3) != 0) begin
                    ri = $urandom_range(0, model.size() - 1);
                    do_read(model[ri].r, model[ri].c, $urandom_range(0, 1), $urandom_range(0, 2));
                end else begin
                    do_read(3'($urandom_range(0, 6)), 3'($urandom_range(1, 5)), $urandom_range(0, 1), 0);
                end
            end else begin
                i_clr = 1'b1;
                tick();
                i_clr = 1'b0;
                model.delete();
                @(negedge clk);
                chk("clr_free", o_free_count, SL);
            end
        end

        // clr, wr_start and rd_start together: clear wins, nothing else happens.
        do_store(3'd2, 3'd2, seqd(8'hD0), 0);
        @(posedge clk); #1;
        i_clr = 1'b1; i_wr_start = 1'b1; i_wr_rows = 3'd1; i_wr_cols = 3'd1;
        i_rd_start = 1'b1; i_rd_rows = 3'd2; i_rd_cols = 3'd2; i_rd_idx = 1'b0;
        tick();
        i_clr = 1'b0; i_wr_start = 1'b0; i_rd_start = 1'b0;
        model.delete();
        i_q_rows = 3'd2; i_q_cols = 3'd2;
        @(negedge clk);
        chk("prio_busy", o_busy, 0);
        chk("prio_wr_err", o_wr_err, 0);
        chk("prio_rd_err", o_rd_err, 0);
        chk("prio_valid", o_out_valid, 0);
        chk("prio_free", o_free_count, SL);
        chk("prio_q22", o_q_count, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
